// File: rtl/pipe_sched.sv
// Pipeline stall/flush scheduler: mult/div busy counter, EXL state machine and
// the EPC/cause latch, producing stall, int_exc_req and eret_req for all stages.
module pipe_sched #(
    parameter int unsigned MULT_LAT  = 5,
    parameter int unsigned DIV_LAT   = 10,
    parameter logic [31:0] PC_KERNEL = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        D_data_stall,
    input  logic        D_md_use,
    input  logic        E_md_start,
    input  logic        E_md_div,
    input  logic        D_eret,
    input  logic [4:0]  M_exc_code,
    input  logic        M_int,
    input  logic        M_DB,
    input  logic [31:0] M_PC,
    input  logic        M_eret,
    output logic        stall,
    output logic        int_exc_req,
    output logic        eret_req,
    output logic        md_busy,
    output logic        exl,
    output logic [31:0] epc,
    output logic [4:0]  cause_code
);

    localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = ($clog2(MAX_LAT + 1) > 4) ? $clog2(MAX_LAT + 1) : 4;
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);

    // The handler entry is consumed by the F-stage redirect mux; it must be word aligned.
    if (PC_KERNEL[1:0] != 2'b00) begin : g_pc_kernel_check
        $error("pipe_sched: PC_KERNEL must be word aligned");
    end

    typedef enum logic {
        USER   = 1'b0,
        KERNEL = 1'b1
    } exl_state_t;

    exl_state_t       exl_state_q, exl_state_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic [31:0]      epc_q, epc_d;
    logic [4:0]       cause_q, cause_d;
    logic             exl_pend_q, exl_pend_d;
    logic             exc_take;
    logic             md_start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exl_state_q <= USER;
            md_cnt_q    <= '0;
            epc_q       <= '0;
            cause_q     <= '0;
            exl_pend_q  <= 1'b0;
        end else begin
            exl_state_q <= exl_state_d;
            md_cnt_q    <= md_cnt_d;
            epc_q       <= epc_d;
            cause_q     <= cause_d;
            exl_pend_q  <= exl_pend_d;
        end
    end

    always_comb begin
        exc_take    = 1'b0;
        exl_state_d = exl_state_q;
        case (exl_state_q)
            USER: begin
                exc_take = (|M_exc_code) | M_int;
                if (exc_take) exl_state_d = KERNEL;
            end
            KERNEL: begin
                if (M_eret) exl_state_d = USER;
            end
            default: exl_state_d = USER;
        endcase
    end

    always_comb begin
        epc_d      = epc_q;
        cause_d    = cause_q;
        exl_pend_d = exc_take;
        if (exc_take) begin
            epc_d   = M_DB ? (M_PC - 32'd4) : M_PC;
            cause_d = M_exc_code;
        end
    end

    // A start is accepted only when idle and not being flushed; an op already
    // counting keeps counting through a flush because it has issued.
    always_comb begin
        md_start = E_md_start & ~md_busy & ~exc_take;
        md_cnt_d = md_cnt_q;
        if (md_start) begin
            md_cnt_d = E_md_div ? DIV_CNT : MULT_CNT;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end
    end

    always_comb begin
        md_busy     = (md_cnt_q != '0);
        exl         = (exl_state_q == KERNEL);
        epc         = epc_q;
        cause_code  = cause_q;
        int_exc_req = exc_take;
        eret_req    = M_eret & ~exc_take;
        stall       = ~exc_take & (D_data_stall
                                   | (D_md_use & (md_busy | E_md_start))
                                   | (D_eret & exl_pend_q));
    end

endmodule

// File: tb/tb_pipe_sched.sv
// Directed bench for pipe_sched: md counter, exception/interrupt entry, eret
// and stall/flush priority, each scenario checked against hand-computed values.
module tb_pipe_sched;

    logic        clk;
    logic        reset;
    logic        D_data_stall;
    logic        D_md_use;
    logic        E_md_start;
    logic        E_md_div;
    logic        D_eret;
    logic [4:0]  M_exc_code;
    logic        M_int;
    logic        M_DB;
    logic [31:0] M_PC;
    logic        M_eret;
    logic        stall;
    logic        int_exc_req;
    logic        eret_req;
    logic        md_busy;
    logic        exl;
    logic [31:0] epc;
    logic [4:0]  cause_code;

    int n_checks = 0;
    int n_errors = 0;

    pipe_sched #(
        .MULT_LAT (5),
        .DIV_LAT  (10),
        .PC_KERNEL(32'h0000_4180)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .D_data_stall(D_data_stall),
        .D_md_use    (D_md_use),
        .E_md_start  (E_md_start),
        .E_md_div    (E_md_div),
        .D_eret      (D_eret),
        .M_exc_code  (M_exc_code),
        .M_int       (M_int),
        .M_DB        (M_DB),
        .M_PC        (M_PC),
        .M_eret      (M_eret),
        .stall       (stall),
        .int_exc_req (int_exc_req),
        .eret_req    (eret_req),
        .md_busy     (md_busy),
        .exl         (exl),
        .epc         (epc),
        .cause_code  (cause_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        D_data_stall = 0; D_md_use = 0; E_md_start = 0; E_md_div = 0; D_eret = 0;
        M_exc_code = 0; M_int = 0; M_DB = 0; M_PC = 0; M_eret = 0;
    endtask

    task automatic test_reset;
        reset = 0;
        clear_inputs();
        #3;
        n_checks++;
        if ({md_busy, exl, stall, int_exc_req, eret_req} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_flags: got %b need 00000", {md_busy, exl, stall, int_exc_req, eret_req});
        end
        n_checks++;
        if (epc !== 32'h0 || cause_code !== 5'd0) begin
            n_errors++;
            $display("FAIL reset_epc_cause: got epc=%h cause=%0d need 0/0", epc, cause_code);
        end
        @(negedge clk);
        reset = 1;
        tick();
        $display("reset: epc=%h cause=%0d exl=%b md_busy=%b", epc, cause_code, exl, md_busy);
    endtask

    task automatic test_md_mult;
        E_md_start = 1; E_md_div = 0; D_md_use = 1;
        #1;
        n_checks++;
        if (stall !== 1'b1 || md_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL mult_c0: got stall=%b busy=%b need 1/0", stall, md_busy);
        end
        for (int c = 1; c <= 5; c++) begin
            tick();
            E_md_start = 0;
            #1;
            n_checks++;
            if (stall !== 1'b1 || md_busy !== 1'b1) begin
                n_errors++;
                $display("FAIL mult_c%0d: got stall=%b busy=%b need 1/1", c, stall, md_busy);
            end
        end
        tick();
        n_checks++;
        if (stall !== 1'b0 || md_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL mult_c6: got stall=%b busy=%b need 0/0", stall, md_busy);
        end
        D_md_use = 0;
        $display("mult: busy window done, md_busy=%b", md_busy);
    endtask

    task automatic test_md_div;
        int n;
        E_md_start = 1; E_md_div = 1;
        tick();
        E_md_start = 0;
        n = 0;
        while (md_busy === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        n_checks++;
        if (n !== 10) begin
            n_errors++;
            $display("FAIL div_len: got %0d busy cycles need 10", n);
        end
        $display("div: busy cycles=%0d", n);
        // Second division aborted by asynchronous reset at cycle 4.
        E_md_start = 1;
        tick();
        E_md_start = 0;
        tick(); tick(); tick();
        n_checks++;
        if (md_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL div_c4_busy: got %b need 1", md_busy);
        end
        #2 reset = 0;
        #1;
        n_checks++;
        if (md_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset_busy: got %b need 0", md_busy);
        end
        $display("div: async reset mid-count, md_busy=%b", md_busy);
        @(negedge clk);
        E_md_div = 0;
        reset = 1;
        tick();
    endtask

    task automatic test_exception;
        M_exc_code = 5'd4; M_PC = 32'h3010; M_DB = 1;
        #1;
        n_checks++;
        if (int_exc_req !== 1'b1 || eret_req !== 1'b0) begin
            n_errors++;
            $display("FAIL exc_req: got int_exc_req=%b eret_req=%b need 1/0", int_exc_req, eret_req);
        end
        tick();
        M_exc_code = 0; M_DB = 0; M_PC = 32'h3050;
        #1;
        n_checks++;
        if (epc !== 32'h300C || cause_code !== 5'd4 || exl !== 1'b1) begin
            n_errors++;
            $display("FAIL exc_latch: got epc=%h cause=%0d exl=%b need 0000300c/4/1", epc, cause_code, exl);
        end
        M_int = 1;
        #1;
        n_checks++;
        if (int_exc_req !== 1'b0) begin
            n_errors++;
            $display("FAIL exc_masked: got int_exc_req=%b need 0", int_exc_req);
        end
        tick();
        n_checks++;
        if (epc !== 32'h300C || exl !== 1'b1) begin
            n_errors++;
            $display("FAIL exc_hold: got epc=%h exl=%b need 0000300c/1", epc, exl);
        end
        M_int = 0; M_eret = 1;
        #1;
        n_checks++;
        if (eret_req !== 1'b1) begin
            n_errors++;
            $display("FAIL exc_eret_req: got %b need 1", eret_req);
        end
        tick();
        M_eret = 0;
        #1;
        n_checks++;
        if (exl !== 1'b0) begin
            n_errors++;
            $display("FAIL exc_eret_exl: got %b need 0", exl);
        end
        $display("exception: epc=%h cause=%0d exl=%b", epc, cause_code, exl);
    endtask

    task automatic test_interrupt;
        M_int = 1; M_exc_code = 0; M_DB = 0; M_PC = 32'h3020;
        #1;
        n_checks++;
        if (int_exc_req !== 1'b1) begin
            n_errors++;
            $display("FAIL int_req: got %b need 1", int_exc_req);
        end
        tick();
        M_int = 0; M_PC = 0;
        #1;
        n_checks++;
        if (epc !== 32'h3020 || cause_code !== 5'd0 || exl !== 1'b1) begin
            n_errors++;
            $display("FAIL int_latch: got epc=%h cause=%0d exl=%b need 00003020/0/1", epc, cause_code, exl);
        end
        M_eret = 1;
        #1;
        n_checks++;
        if (eret_req !== 1'b1) begin
            n_errors++;
            $display("FAIL int_eret_req: got %b need 1", eret_req);
        end
        tick();
        M_eret = 0;
        #1;
        n_checks++;
        if (exl !== 1'b0 || eret_req !== 1'b0) begin
            n_errors++;
            $display("FAIL int_eret_exl: got exl=%b eret_req=%b need 0/0", exl, eret_req);
        end
        $display("interrupt: epc=%h cause=%0d exl=%b", epc, cause_code, exl);
    endtask

    task automatic test_flush_priority;
        D_data_stall = 1;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin
            n_errors++;
            $display("FAIL data_stall: got %b need 1", stall);
        end
        M_exc_code = 5'd12; M_PC = 32'h3040; M_eret = 1;
        #1;
        n_checks++;
        if (stall !== 1'b0 || int_exc_req !== 1'b1 || eret_req !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_prio: got stall=%b int=%b eret=%b need 0/1/0", stall, int_exc_req, eret_req);
        end
        tick();
        D_data_stall = 0; M_exc_code = 0; M_eret = 0; D_eret = 1;
        #1;
        n_checks++;
        if (stall !== 1'b1 || exl !== 1'b1 || cause_code !== 5'd12 || epc !== 32'h3040) begin
            n_errors++;
            $display("FAIL eret_wait: got stall=%b exl=%b cause=%0d epc=%h need 1/1/12/00003040",
                     stall, exl, cause_code, epc);
        end
        tick();
        n_checks++;
        if (stall !== 1'b0) begin
            n_errors++;
            $display("FAIL eret_wait_end: got stall=%b need 0", stall);
        end
        D_eret = 0; D_data_stall = 1; M_int = 1;
        #1;
        n_checks++;
        if (stall !== 1'b1 || int_exc_req !== 1'b0) begin
            n_errors++;
            $display("FAIL kernel_stall: got stall=%b int=%b need 1/0", stall, int_exc_req);
        end
        D_data_stall = 0; M_int = 0; M_eret = 1;
        tick();
        M_eret = 0;
        $display("flush_priority: exl=%b stall=%b", exl, stall);
    endtask

    task automatic test_back_to_back;
        // Start coinciding with a flush is dropped.
        E_md_start = 1; M_int = 1; M_PC = 32'h3060;
        tick();
        E_md_start = 0; M_int = 0;
        #1;
        n_checks++;
        if (md_busy !== 1'b0 || exl !== 1'b1) begin
            n_errors++;
            $display("FAIL md_blocked: got busy=%b exl=%b need 0/1", md_busy, exl);
        end
        M_eret = 1;
        tick();
        M_eret = 0;
        // A counting op survives a later flush.
        E_md_start = 1;
        tick();
        E_md_start = 0; M_int = 1;
        #1;
        n_checks++;
        if (int_exc_req !== 1'b1 || md_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL md_flush_c1: got int=%b busy=%b need 1/1", int_exc_req, md_busy);
        end
        tick();
        M_int = 0;
        #1;
        n_checks++;
        if (md_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL md_not_aborted: got busy=%b need 1", md_busy);
        end
        tick(); tick(); tick(); tick();
        n_checks++;
        if (md_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL md_drain: got busy=%b need 0", md_busy);
        end
        M_eret = 1;
        tick();
        M_eret = 0;
        $display("back_to_back: md_busy=%b exl=%b", md_busy, exl);
    endtask

    initial begin
        test_reset();
        test_md_mult();
        test_md_div();
        test_exception();
        test_interrupt();
        test_flush_priority();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
